// File: rtl/runtime_load_table_pkg.sv
// Shared constants and load FSM state encoding for runtime_load_table.
package runtime_load_table_pkg;

    localparam int unsigned PC_W        = 12;
    localparam int unsigned TABLE_DEPTH = 4096;
    localparam int unsigned BEAT_BYTES  = 64;
    localparam int unsigned BEAT_SHIFT  = $clog2(BEAT_BYTES);
    localparam int unsigned MAX_BURST   = 256;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } load_state_e;

endpackage

// File: rtl/runtime_load_table_if.sv
// Control handshake plus AXI4 read-only channel (AR/R) used by runtime_load_table.
interface runtime_load_table_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 512,
    parameter int unsigned XFER_W = 64
);
    logic              ctrl_start;
    logic              ctrl_done;
    logic [ADDR_W-1:0] ctrl_addr_offset;
    logic [XFER_W-1:0] ctrl_xfer_size_in_bytes;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic              m_axi_rvalid;
    logic              m_axi_rready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic              m_axi_rlast;

    modport master (
        input  ctrl_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        output ctrl_done, m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready
    );

    modport slave (
        output ctrl_start, ctrl_addr_offset, ctrl_xfer_size_in_bytes,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        input  ctrl_done, m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready
    );
endinterface

// File: rtl/load_table_ram.sv
// One-write, one-registered-read instruction table; read-first on same-address collision.
module load_table_ram
    import runtime_load_table_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [PC_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [PC_W-1:0]   i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [TABLE_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/runtime_load_table.sv
// Per-column instruction store: AXI read loader, per-column PCs, optional cycle counter.
// Define LOADTABLE_CYCLE_COUNTER_EN to enable cycle_register; otherwise it is tied to 0.
module runtime_load_table
    import runtime_load_table_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH  = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH  = 512,
    parameter int unsigned C_XFER_SIZE_WIDTH   = 64,
    parameter int unsigned C_MAX_OUTSTANDING   = 16,
    parameter int unsigned C_INCLUDE_DATA_FIFO = 1,
    parameter int unsigned num_col             = 2,
    parameter int unsigned dwidth_int          = 32
) (
    input  logic                             aclk,
    input  logic                             areset,
    runtime_load_table_if.master             m_if,
    input  logic [num_col-1:0]               clken_PC,
    input  logic [num_col-1:0]               load_PC,
    input  logic [num_col-1:0]               incr_PC,
    input  logic [num_col*PC_W-1:0]          load_value_PC,
    output logic [num_col*PC_W-1:0]          PC,
    output logic [dwidth_int-1:0]            cycle_register,
    output logic [num_col*dwidth_int-1:0]    instr
);
    localparam int unsigned XFER_W = C_XFER_SIZE_WIDTH;
    localparam int unsigned ADDR_W = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned COL_W  = (num_col > 1) ? $clog2(num_col) : 1;
    localparam int unsigned OUT_W  = $clog2(C_MAX_OUTSTANDING + 1);

    load_state_e       r_state;
    logic [ADDR_W-1:0] r_offset;
    logic [XFER_W-1:0] r_total;
    logic [XFER_W-1:0] r_req;
    logic [XFER_W-1:0] r_acc;
    logic [PC_W-1:0]   r_wr_idx;
    logic [COL_W-1:0]  r_col_ptr;
    logic [OUT_W-1:0]  r_outstanding;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic              r_rready;
    logic              r_ctrl_done;

    logic              w_beat;
    logic              w_ar_hs;
    logic              w_burst_end;
    logic [XFER_W-1:0] w_remaining;
    logic [XFER_W-1:0] w_burst;
    logic [XFER_W-1:0] w_start_beats;
    logic              w_unused;

    assign w_beat        = r_rready & m_if.m_axi_rvalid;
    assign w_ar_hs       = r_arvalid & m_if.m_axi_arready;
    assign w_burst_end   = w_beat & m_if.m_axi_rlast;
    assign w_remaining   = r_total - r_req;
    assign w_burst       = (w_remaining > XFER_W'(MAX_BURST)) ? XFER_W'(MAX_BURST) : w_remaining;
    assign w_start_beats = (m_if.ctrl_xfer_size_in_bytes >> BEAT_SHIFT)
                         + XFER_W'(|m_if.ctrl_xfer_size_in_bytes[BEAT_SHIFT-1:0]);
    assign w_unused      = ^{m_if.m_axi_rdata[C_M_AXI_DATA_WIDTH-1:dwidth_int],
                             C_INCLUDE_DATA_FIFO != 0};

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= StIdle;
            r_offset      <= '0;
            r_total       <= '0;
            r_req         <= '0;
            r_acc         <= '0;
            r_wr_idx      <= '0;
            r_col_ptr     <= '0;
            r_outstanding <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_rready      <= 1'b0;
            r_ctrl_done   <= 1'b0;
        end else begin
            r_ctrl_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (m_if.ctrl_start) begin
                        r_offset      <= m_if.ctrl_addr_offset;
                        r_total       <= w_start_beats;
                        r_req         <= '0;
                        r_acc         <= '0;
                        r_wr_idx      <= '0;
                        r_outstanding <= '0;
                        if (w_start_beats == '0) begin
                            r_state     <= StDone;
                            r_ctrl_done <= 1'b1;
                        end else begin
                            r_state  <= StBusy;
                            r_rready <= 1'b1;
                        end
                    end
                end
                StBusy: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_req     <= r_req + XFER_W'(r_arlen) + XFER_W'(1);
                    end else if (!r_arvalid && (r_req < r_total)
                                 && (r_outstanding < OUT_W'(C_MAX_OUTSTANDING))) begin
                        r_arvalid <= 1'b1;
                        r_araddr  <= r_offset + (ADDR_W'(r_req) << BEAT_SHIFT);
                        r_arlen   <= 8'(w_burst - XFER_W'(1));
                    end
                    // rlast only tracks bursts in flight; completion is by beat count.
                    if (w_ar_hs && !w_burst_end) begin
                        r_outstanding <= r_outstanding + OUT_W'(1);
                    end else if (!w_ar_hs && w_burst_end && (r_outstanding != '0)) begin
                        r_outstanding <= r_outstanding - OUT_W'(1);
                    end
                    if (w_beat) begin
                        r_acc    <= r_acc + XFER_W'(1);
                        r_wr_idx <= r_wr_idx + PC_W'(1);
                        if ((r_acc + XFER_W'(1)) == r_total) begin
                            r_state     <= StDone;
                            r_arvalid   <= 1'b0;
                            r_rready    <= 1'b0;
                            r_ctrl_done <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_col_ptr <= (r_col_ptr == COL_W'(num_col - 1)) ? '0
                                                                    : r_col_ptr + COL_W'(1);
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign m_if.ctrl_done     = r_ctrl_done;
    assign m_if.m_axi_arvalid = r_arvalid;
    assign m_if.m_axi_araddr  = r_araddr;
    assign m_if.m_axi_arlen   = r_arlen;
    assign m_if.m_axi_rready  = r_rready;

    for (genvar c = 0; c < num_col; c++) begin : g_col
        logic [PC_W-1:0] r_pc;
        logic            w_we;

        always_ff @(posedge aclk) begin
            if (areset) begin
                r_pc <= '0;
            end else if (clken_PC[c]) begin
                if (load_PC[c]) begin
                    r_pc <= load_value_PC[c*PC_W +: PC_W];
                end else if (incr_PC[c]) begin
                    r_pc <= r_pc + PC_W'(1);
                end
            end
        end

        assign w_we = w_beat && (r_col_ptr == COL_W'(c));
        assign PC[c*PC_W +: PC_W] = r_pc;

        load_table_ram #(
            .DATA_W (dwidth_int)
        ) u_ram (
            .clk     (aclk),
            .rst     (areset),
            .i_we    (w_we),
            .i_waddr (r_wr_idx),
            .i_wdata (m_if.m_axi_rdata[dwidth_int-1:0]),
            .i_raddr (r_pc),
            .o_rdata (instr[c*dwidth_int +: dwidth_int])
        );
    end

`ifdef LOADTABLE_CYCLE_COUNTER_EN
    logic [dwidth_int-1:0] r_cycle;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cycle <= '0;
        end else if (|clken_PC) begin
            r_cycle <= r_cycle + dwidth_int'(1);
        end
    end

    assign cycle_register = r_cycle;
`else
    assign cycle_register = '0;
`endif
endmodule

// File: tb/tb_runtime_load_table.sv
// Self-checking bench for runtime_load_table: directed loads, PC vector table, random PC ops.
module tb_runtime_load_table;
    logic        aclk;
    logic        areset;
    logic [1:0]  clken_PC, load_PC, incr_PC;
    logic [23:0] load_value_PC;
    logic [23:0] PC;
    logic [31:0] cycle_register;
    logic [63:0] instr;

    runtime_load_table_if bus ();

    runtime_load_table dut (
        .aclk           (aclk),
        .areset         (areset),
        .m_if           (bus),
        .clken_PC       (clken_PC),
        .load_PC        (load_PC),
        .incr_PC        (incr_PC),
        .load_value_PC  (load_value_PC),
        .PC             (PC),
        .cycle_register (cycle_register),
        .instr          (instr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl_tab [2][4096];
    int          mdl_col = 0;
    int          mdl_pc [2];
    logic [31:0] mdl_cyc = 0;
    logic [31:0] data_q [$];

    typedef struct {
        logic [1:0]  clken, load, incr;
        logic [11:0] v0, v1, pc0, pc1;
        logic        chk_i;
        logic [31:0] i0, i1;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cycle();
`ifdef LOADTABLE_CYCLE_COUNTER_EN
        return mdl_cyc;
`else
        return 32'h0;
`endif
    endfunction

    task automatic tick();
        if (areset) mdl_cyc = 0;
        else if (|clken_PC) mdl_cyc = mdl_cyc + 1;
        @(posedge aclk);
        #1;
    endtask

    // Sequential AXI slave: waits for each AR, checks it, returns its beats in order.
    task automatic do_load(input logic [63:0] off, input logic [63:0] size, input int ar_delay);
        longint unsigned total, req, acc, burst;
        int              n;
        logic [31:0]     dat;
        logic [511:0]    d;
        total = (size + 63) / 64;
        bus.ctrl_addr_offset        = off;
        bus.ctrl_xfer_size_in_bytes = size;
        bus.ctrl_start              = 1'b1;
        tick();
        bus.ctrl_start = 1'b0;
        if (total == 0) begin
            check("zero_done", 64'(bus.ctrl_done), 64'd1);
            check("zero_no_ar", 64'(bus.m_axi_arvalid), 64'd0);
        end else begin
            check("rready_busy", 64'(bus.m_axi_rready), 64'd1);
            req = 0;
            acc = 0;
            while (acc < total) begin
                burst = (total - req > 256) ? 256 : total - req;
                n = 0;
                while (!bus.m_axi_arvalid && n < 50) begin
                    tick();
                    n++;
                end
                if (!bus.m_axi_arvalid) begin
                    check("ar_timeout", 64'd0, 64'd1);
                    return;
                end
                check("araddr", bus.m_axi_araddr, off + 64'(64 * req));
                check("arlen", 64'(bus.m_axi_arlen), 64'(burst - 1));
                if (ar_delay > 0) begin
                    repeat (ar_delay) tick();
                    check("arvalid_hold", 64'(bus.m_axi_arvalid), 64'd1);
                end
                bus.m_axi_arready = 1'b1;
                tick();
                bus.m_axi_arready = 1'b0;
                req += burst;
                for (longint unsigned b = 0; b < burst; b++) begin
                    if (data_q.size() > 0) dat = data_q.pop_front();
                    else dat = $urandom();
                    d = {16{$urandom()}};
                    d[31:0] = dat;
                    bus.m_axi_rdata  = d;
                    bus.m_axi_rvalid = 1'b1;
                    bus.m_axi_rlast  = (b == burst - 1);
                    tick();
                    mdl_tab[mdl_col][acc % 4096] = dat;
                    acc++;
                end
                bus.m_axi_rvalid = 1'b0;
                bus.m_axi_rlast  = 1'b0;
            end
            check("done_after_last", 64'(bus.ctrl_done), 64'd1);
            check("arvalid_at_done", 64'(bus.m_axi_arvalid), 64'd0);
        end
        tick();
        check("done_one_cycle", 64'(bus.ctrl_done), 64'd0);
        mdl_col = (mdl_col + 1) % 2;
    endtask

    task automatic apply_pc(input logic [1:0] c, input logic [1:0] l, input logic [1:0] i,
                            input logic [11:0] v0, input logic [11:0] v1);
        clken_PC      = c;
        load_PC       = l;
        incr_PC       = i;
        load_value_PC = {v1, v0};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int old0, old1;
        logic [1:0] rc, rl, ri;
        logic [11:0] rv0, rv1;

        vecs[0] = '{2'b11, 2'b11, 2'b00, 12'd0,    12'd0,    12'd0,    12'd0,    1'b1,
                    32'h11111111, 32'h55555555};
        vecs[1] = '{2'b11, 2'b00, 2'b11, 12'd0,    12'd0,    12'd1,    12'd1,    1'b1,
                    32'h11111111, 32'h55555555};
        vecs[2] = '{2'b11, 2'b00, 2'b11, 12'd0,    12'd0,    12'd2,    12'd2,    1'b1,
                    32'h22222222, 32'h66666666};
        vecs[3] = '{2'b11, 2'b00, 2'b11, 12'd0,    12'd0,    12'd3,    12'd3,    1'b1,
                    32'h33333333, 32'h77777777};
        vecs[4] = '{2'b00, 2'b00, 2'b11, 12'd0,    12'd0,    12'd3,    12'd3,    1'b1,
                    32'h44444444, 32'h88888888};
        vecs[5] = '{2'b11, 2'b11, 2'b11, 12'd1,    12'd2,    12'd1,    12'd2,    1'b1,
                    32'h44444444, 32'h88888888};
        vecs[6] = '{2'b10, 2'b00, 2'b11, 12'd0,    12'd0,    12'd1,    12'd3,    1'b1,
                    32'h22222222, 32'h77777777};
        vecs[7] = '{2'b11, 2'b11, 2'b00, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 1'b1,
                    32'h22222222, 32'h88888888};
        vecs[8] = '{2'b11, 2'b00, 2'b11, 12'd0,    12'd0,    12'd0,    12'd0,    1'b0,
                    32'h0,        32'h0};
        vecs[9] = '{2'b11, 2'b00, 2'b00, 12'd0,    12'd0,    12'd0,    12'd0,    1'b1,
                    32'h11111111, 32'h55555555};

        areset = 1'b1;
        apply_pc(2'b00, 2'b00, 2'b00, 12'd0, 12'd0);
        bus.ctrl_start              = 1'b0;
        bus.ctrl_addr_offset        = '0;
        bus.ctrl_xfer_size_in_bytes = '0;
        bus.m_axi_arready           = 1'b0;
        bus.m_axi_rvalid            = 1'b0;
        bus.m_axi_rdata             = '0;
        bus.m_axi_rlast             = 1'b0;
        repeat (3) tick();
        areset = 1'b0;
        check("rst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        check("rst_rready", 64'(bus.m_axi_rready), 64'd0);
        check("rst_done", 64'(bus.ctrl_done), 64'd0);
        check("rst_pc", 64'(PC), 64'd0);
        check("rst_instr", instr, 64'd0);
        check("rst_cycle", 64'(cycle_register), 64'(exp_cycle()));

        data_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        do_load(64'd0, 64'hff, 2);
        data_q = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        do_load(64'd8, 64'hff, 0);

        foreach (vecs[k]) begin
            apply_pc(vecs[k].clken, vecs[k].load, vecs[k].incr, vecs[k].v0, vecs[k].v1);
            tick();
            check($sformatf("vec%0d_pc", k), 64'(PC), 64'({vecs[k].pc1, vecs[k].pc0}));
            if (vecs[k].chk_i)
                check($sformatf("vec%0d_instr", k), instr, {vecs[k].i1, vecs[k].i0});
            check($sformatf("vec%0d_cycle", k), 64'(cycle_register), 64'(exp_cycle()));
        end
        apply_pc(2'b00, 2'b00, 2'b00, 12'd0, 12'd0);

        do_load(64'h1234, 64'd0, 0);

        // Interrupted load on column 1; reset must return the pointer to column 0.
        bus.ctrl_addr_offset        = 64'h4000;
        bus.ctrl_xfer_size_in_bytes = 64'h400;
        bus.ctrl_start              = 1'b1;
        tick();
        bus.ctrl_start = 1'b0;
        tick();
        bus.m_axi_arready = 1'b1;
        tick();
        bus.m_axi_arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.m_axi_rdata  = 512'($urandom());
            bus.m_axi_rvalid = 1'b1;
            tick();
            mdl_tab[1][b] = bus.m_axi_rdata[31:0];
        end
        bus.m_axi_rvalid = 1'b0;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("midrst_arvalid", 64'(bus.m_axi_arvalid), 64'd0);
        check("midrst_rready", 64'(bus.m_axi_rready), 64'd0);
        check("midrst_done", 64'(bus.ctrl_done), 64'd0);
        check("midrst_pc", 64'(PC), 64'd0);
        check("midrst_cycle", 64'(cycle_register), 64'(exp_cycle()));
        mdl_col = 0;

        do_load({32'h1, $urandom()}, 64'd4099 * 64, 0);
        do_load({$urandom(), 32'h0}, 64'd4096 * 64 - 5, 1);

        apply_pc(2'b11, 2'b11, 2'b00, 12'd0, 12'd0);
        tick();
        mdl_pc[0] = 0;
        mdl_pc[1] = 0;
        for (int n = 0; n < 400; n++) begin
            rc  = 2'($urandom());
            rl  = 2'($urandom_range(0, 3) == 0 ? $urandom() : 0);
            ri  = 2'($urandom_range(0, 3) != 0 ? 3 : $urandom());
            rv0 = ($urandom_range(0, 7) == 0) ? 12'd4094 : 12'($urandom());
            rv1 = ($urandom_range(0, 7) == 0) ? 12'd4095 : 12'($urandom());
            apply_pc(rc, rl, ri, rv0, rv1);
            old0 = mdl_pc[0];
            old1 = mdl_pc[1];
            for (int c = 0; c < 2; c++) begin
                if (rc[c]) begin
                    if (rl[c]) mdl_pc[c] = (c == 0) ? int'(rv0) : int'(rv1);
                    else if (ri[c]) mdl_pc[c] = (mdl_pc[c] + 1) % 4096;
                end
            end
            tick();
            check("rnd_pc", 64'(PC), 64'({12'(mdl_pc[1]), 12'(mdl_pc[0])}));
            check("rnd_instr", instr, {mdl_tab[1][old1], mdl_tab[0][old0]});
            check("rnd_cycle", 64'(cycle_register), 64'(exp_cycle()));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
